// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART definitions (state encoding, frame constants) used
//             by the transmitter and intended for reuse by a future receiver.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Data bits per frame (8N1 framing).
  localparam int unsigned DATA_BITS = 8;

  // Default bit period: 50 MHz / 9600 baud.
  localparam logic [15:0] CLKS_PER_BIT_DEFAULT = 16'd5208;

  // Index of the last data bit shifted out, sized to the bit-index register.
  localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_BITS - 1);

  // Transmitter frame phases; LEAD is a one-bit idle guard before START.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_counter
//  Brief    : Bit-period timer. Counts 0..CLKS_PER_BIT-1 and flags the last
//             cycle of each bit period; held at zero while clear_i is high.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter logic [15:0] CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic bit_tick_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        last_w;

  assign last_w     = (cnt_q == (CLKS_PER_BIT - 16'd1));
  // A cleared counter never ticks, so the FSM cannot advance while idle.
  assign bit_tick_o = last_w && !clear_i;

  // Next count: wrap at the bit boundary, hold at zero while cleared.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clear_i || last_w) begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Brief    : Transmit-only 8N1 UART serializer, LSB first. A one-cycle
//             enable in IDLE latches writedata and sends an 11-bit-period
//             frame (idle guard, start, 8 data, stop); done pulses for one
//             cycle as the FSM returns to IDLE.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter logic [15:0] CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] writedata,
  input  logic       enable,
  output logic       done,
  output logic       tx
);

  uart_state_e state_q;
  uart_state_e state_d;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic [2:0]  bit_idx_q;
  logic [2:0]  bit_idx_d;
  logic        tx_q;
  logic        tx_d;
  logic        done_q;
  logic        done_d;
  logic        baud_clear_w;
  logic        bit_tick_w;

  // The bit timer is held at zero in IDLE so that the first bit period
  // starts exactly on the accepting edge.
  assign baud_clear_w = (state_q == IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clock_i    (clock),
    .reset_i    (resetn),
    .clear_i    (baud_clear_w),
    .bit_tick_o (bit_tick_w)
  );

  // Next-state logic; tx_d is the value the line takes for the next bit.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (enable) begin
          shift_d   = writedata;
          bit_idx_d = '0;
          state_d   = LEAD;
        end
      end

      LEAD: begin
        if (bit_tick_w) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (bit_tick_w) begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end

      DATA: begin
        if (bit_tick_w) begin
          if (bit_idx_q == LAST_DATA_IDX) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      STOP: begin
        if (bit_tick_w) begin
          tx_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame without a done pulse.
  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign tx   = tx_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Brief    : Self-checking bench for uart_tx. Three instances: a short bit
//             period for most scenarios, a 4-clock period, and the default.
//             Expected line values come from the frame rules: bit period
//             b = cycle / N carries 1 (guard), 0 (start), data[b-2], 1 (stop).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int N  = 16;
  localparam int NS = 4;
  localparam int ND = 5208;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Main instance (N = 16, positional override)
  logic       rst_m = 1'b1, en_m = 1'b0, done_m, tx_m;
  logic [7:0] wd_m  = 8'h00;
  // Small instance (N = 4)
  logic       rst_s = 1'b1, en_s = 1'b0, done_s, tx_s;
  logic [7:0] wd_s  = 8'h00;
  // Default instance (N = 5208)
  logic       rst_d = 1'b1, en_d = 1'b0, done_d, tx_d;
  logic [7:0] wd_d  = 8'h00;

  uart_tx #(16'd16) dut_main (
    .clock(clock), .resetn(rst_m), .writedata(wd_m), .enable(en_m), .done(done_m), .tx(tx_m)
  );
  uart_tx #(.CLKS_PER_BIT(16'd4)) dut_small (
    .clock(clock), .resetn(rst_s), .writedata(wd_s), .enable(en_s), .done(done_s), .tx(tx_s)
  );
  uart_tx dut_default (
    .clock(clock), .resetn(rst_d), .writedata(wd_d), .enable(en_d), .done(done_d), .tx(tx_d)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected line level cyc cycles after the accepting edge.
  function automatic logic model_tx(input logic [7:0] d, input int n, input int cyc);
    int b;
    b = cyc / n;
    if (b == 1) return 1'b0;
    if (b >= 2 && b <= 9) return d[b-2];
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One frame on the main instance, called just after an edge with the DUT
  // idle. Returns right after the done edge so a follow-up call is back-to-back.
  task automatic send_main(input logic [7:0] d, input int glitch_cyc, input bit hold, input string tag);
    int   bad_cyc = -1;
    logic bad_act = 1'b0;
    int   dones   = 0;
    int   done_at = -1;
    wd_m = d;
    en_m = 1'b1;
    tick();
    if (!hold) en_m = 1'b0;
    for (int cyc = 0; cyc <= 11 * N; cyc++) begin
      if (cyc > 0) tick();
      if (tx_m !== model_tx(d, N, cyc) && bad_cyc < 0) begin
        bad_cyc = cyc;
        bad_act = tx_m;
      end
      if (done_m !== 1'b0) begin
        dones++;
        done_at = cyc;
      end
      if (cyc == 0) wd_m = 8'($urandom);
      if (cyc == glitch_cyc) begin
        en_m = 1'b1;
        wd_m = 8'h55;
      end else if (cyc == glitch_cyc + 1 && !hold) begin
        en_m = 1'b0;
      end
    end
    tests_run++;
    if (bad_cyc >= 0) begin
      tests_failed++;
      $display("FAIL %s tx data=%02h cycle %0d: got %b expected %b", tag, d, bad_cyc, bad_act,
               model_tx(d, N, bad_cyc));
    end
    tests_run++;
    if (dones !== 1 || done_at !== 11 * N) begin
      tests_failed++;
      $display("FAIL %s done: got %0d pulses last at cycle %0d, expected 1 at cycle %0d",
               tag, dones, done_at, 11 * N);
    end
  endtask

  // Check the main line stays idle with no done for the given cycles.
  task automatic check_idle_main(input int cycles, input string tag);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (tx_m !== 1'b1 || done_m !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL %s: %0d cycles not idle, expected 0 (tx=1 done=0)", tag, bad);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    rst_m = 1'b1; rst_s = 1'b1; rst_d = 1'b1;
    en_m = 1'b0; en_s = 1'b0; en_d = 1'b0;
    tick(); tick();
    tests_run++;
    if ({tx_m, done_m, tx_s, done_s, tx_d, done_d} !== 6'b101010) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 101010",
               {tx_m, done_m, tx_s, done_s, tx_d, done_d});
    end
    rst_m = 1'b0; rst_s = 1'b0; rst_d = 1'b0;
    for (int i = 0; i < 3 * N; i++) begin
      tick();
      if ({tx_m, done_m, tx_s, done_s, tx_d, done_d} !== 6'b101010) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL reset_idle: %0d cycles not idle, expected 0", bad);
    end
  endtask

  task automatic test_basic();
    send_main(8'hAA, -1, 1'b0, "frame_AA");
    check_idle_main(2, "after_AA");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      send_main(8'($urandom), -1, 1'b0, "random_frame");
      for (int g = $urandom_range(0, 5); g > 0; g--) tick();
    end
  endtask

  task automatic test_back_to_back();
    send_main(8'hAB, -1, 1'b0, "b2b_AB");
    send_main(8'hAC, -1, 1'b0, "b2b_AC");
    send_main(8'hAD, -1, 1'b0, "b2b_AD");
    send_main(8'hAF, -1, 1'b0, "b2b_AF");
    check_idle_main(N, "after_b2b");
  endtask

  task automatic test_held_enable();
    send_main(8'($urandom), -1, 1'b1, "held_first");
    send_main(8'($urandom), -1, 1'b1, "held_second");
    en_m = 1'b0;
    check_idle_main(N, "after_held");
  endtask

  task automatic test_ignored_enable();
    send_main(8'hAA, 3 * N - 1, 1'b0, "midframe_enable");
    check_idle_main(2 * N, "midframe_ignored");
  endtask

  task automatic test_reset_abort();
    logic [7:0] d = 8'hA5;
    int bad_cyc = -1;
    int bad = 0;
    wd_m = d;
    en_m = 1'b1;
    tick();
    en_m = 1'b0;
    for (int cyc = 0; cyc < 5 * N; cyc++) begin
      if (cyc > 0) tick();
      if ((tx_m !== model_tx(d, N, cyc) || done_m !== 1'b0) && bad_cyc < 0) bad_cyc = cyc;
    end
    tests_run++;
    if (bad_cyc >= 0) begin
      tests_failed++;
      $display("FAIL abort_prefix cycle %0d: got tx=%b expected %b", bad_cyc, tx_m,
               model_tx(d, N, bad_cyc));
    end
    rst_m = 1'b1;
    tick();
    tests_run++;
    if (tx_m !== 1'b1 || done_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_reset: got tx=%b done=%b expected tx=1 done=0", tx_m, done_m);
    end
    rst_m = 1'b0;
    for (int i = 0; i < 12 * N; i++) begin
      tick();
      if (tx_m !== 1'b1 || done_m !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL abort_quiet: %0d cycles active, expected 0", bad);
    end
    send_main(8'h3C, -1, 1'b0, "after_abort_3C");
  endtask

  task automatic test_small_divider();
    logic [7:0] d = 8'h01;
    int bad_cyc = -1;
    int done_at = -1;
    int dones = 0;
    wd_s = d;
    en_s = 1'b1;
    tick();
    en_s = 1'b0;
    for (int cyc = 0; cyc <= 11 * NS + 2; cyc++) begin
      if (cyc > 0) tick();
      if (tx_s !== model_tx(d, NS, cyc) && bad_cyc < 0) bad_cyc = cyc;
      if (done_s !== 1'b0) begin
        dones++;
        done_at = cyc;
      end
    end
    tests_run++;
    if (bad_cyc >= 0) begin
      tests_failed++;
      $display("FAIL small_tx cycle %0d: got %b expected %b", bad_cyc, tx_s,
               model_tx(d, NS, bad_cyc));
    end
    tests_run++;
    if (dones !== 1 || done_at !== 44) begin
      tests_failed++;
      $display("FAIL small_done: got %0d pulses last at %0d, expected 1 at 44", dones, done_at);
    end
  endtask

  // Default divider: check guard, start and first data bit timing only.
  task automatic test_default_divider();
    logic [7:0] d = 8'($urandom);
    int bad_cyc = -1;
    wd_d = d;
    en_d = 1'b1;
    tick();
    en_d = 1'b0;
    for (int cyc = 0; cyc <= 2 * ND; cyc++) begin
      if (cyc > 0) tick();
      if ((tx_d !== model_tx(d, ND, cyc) || done_d !== 1'b0) && bad_cyc < 0) bad_cyc = cyc;
    end
    tests_run++;
    if (bad_cyc >= 0) begin
      tests_failed++;
      $display("FAIL default_timing cycle %0d: got tx=%b done=%b expected tx=%b done=0",
               bad_cyc, tx_d, done_d, model_tx(d, ND, bad_cyc));
    end
    rst_d = 1'b1;
    tick();
    rst_d = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_held_enable();
    test_ignored_enable();
    test_reset_abort();
    test_small_divider();
    test_default_divider();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
